// File: rtl/risc16_ctrl_if.sv
// Control-side bundle between the RISC-16 sequencer and its datapath/memory.
// The master modport is the sequencer; the slave modport is the datapath.
interface risc16_ctrl_if;
  logic [15:0] instr;
  logic        mem_ack;
  logic        alu_eq;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_load;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        we_rf;
  logic [1:0]  mux_rf;
  logic        mux_tgt;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [2:0]  state;
  logic        halted;
  logic        fault;

  modport master (
    input  instr, mem_ack, alu_eq,
    output mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, we_rf,
           mux_rf, mux_tgt, alu_op, alu_src, state, halted, fault
  );

  modport slave (
    output instr, mem_ack, alu_eq,
    input  mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, we_rf,
           mux_rf, mux_tgt, alu_op, alu_src, state, halted, fault
  );
endinterface

// File: rtl/risc16_ctrl.sv
// Multi-cycle RISC-16 control sequencer: fetch over a req/ack handshake,
// decode, execute, memory and write-back, with a memory-wait watchdog.
module risc16_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  risc16_ctrl_if.master bus
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  state_e        state_q, state_d;
  opcode_e       op_q, op_d;
  logic [2:0]    ra_q, ra_d;
  logic          imm_nz_q, imm_nz_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;

  logic req_active;
  logic ack;
  logic wd_expire;
  logic unused_instr;

  // An ack only counts while a request is actually outstanding.
  assign req_active   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack          = req_active & bus.mem_ack;
  assign wd_expire    = req_active & ~bus.mem_ack & (wait_q == CW'(WAIT_MAX - 1));
  assign unused_instr = ^bus.instr[9:7];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= OP_ADD;
      ra_q     <= '0;
      imm_nz_q <= 1'b0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      imm_nz_q <= imm_nz_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // NOTE: every variable gets a default at the top of each always_comb so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    imm_nz_d = imm_nz_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    wait_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (ack) begin
          op_d     = opcode_e'(bus.instr[15:13]);
          ra_d     = bus.instr[12:10];
          imm_nz_d = |bus.instr[6:0];
          state_d  = S_DECODE;
        end else if (wd_expire) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_SW, OP_LW: state_d = S_MEM;
          OP_BEQ:       state_d = S_FETCH;
          OP_JALR: begin
            if (imm_nz_q) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              state_d = S_WB;
            end
          end
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (ack) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wd_expire) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      // Unused encodings fall back into the fetch loop.
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_load      = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_sel       = 2'd0;
    bus.we_rf        = 1'b0;
    bus.mux_rf       = 2'd0;
    bus.mux_tgt      = 1'b0;
    bus.alu_op       = 2'd0;
    bus.alu_src      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_load = bus.mem_ack;
        end
        S_DECODE: bus.mux_tgt = (op_q == OP_SW) || (op_q == OP_BEQ);
        S_EXEC: begin
          case (op_q)
            OP_ADDI, OP_SW, OP_LW: bus.alu_src = 1'b1;
            OP_NAND: bus.alu_op = 2'd1;
            OP_LUI:  bus.alu_op = 2'd2;
            OP_BEQ: begin
              bus.alu_op  = 2'd3;
              bus.pc_load = 1'b1;
              bus.pc_sel  = bus.alu_eq ? 2'd1 : 2'd0;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = (op_q == OP_SW);
          bus.pc_load      = bus.mem_ack && (op_q == OP_SW);
        end
        S_WB: begin
          // r0 is hard-wired; the PC still advances.
          bus.we_rf   = (ra_q != 3'd0);
          bus.pc_load = 1'b1;
          if (op_q == OP_LW) begin
            bus.mux_rf = 2'd1;
          end else if (op_q == OP_JALR) begin
            bus.mux_rf = 2'd2;
            bus.pc_sel = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state  = state_q;
  assign bus.halted = halted_q & ~fault_q & ~rst;
  assign bus.fault  = fault_q & ~rst;

endmodule

// File: tb/tb_risc16_ctrl.sv
// Bench for risc16_ctrl: table of instructions with per-instruction summaries
// checked through a scoreboard queue, plus reset, halt and watchdog sequences.
module tb_risc16_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  risc16_ctrl_if bus ();

  risc16_ctrl #(.WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        eq;
    int          dly;
    int          cycles;
    int          n_we;
    int          n_pc;
    int          pc_sel;
    int          mux_rf;
    int          alu_op;
    int          alu_src;
    int          mux_tgt;
    int          n_mreq;
    int          mem_we;
    int          end_state;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t o;
    vec_t e;
    int   wait_n;
    int   n_ir;
    int   st;
    bit   done;
    o = '{default: 0};
    exp_q.push_back(v);
    wait_n = 0;
    n_ir   = 0;
    done   = 1'b0;
    bus.instr  = v.instr;
    bus.alu_eq = v.eq;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      st = int'(bus.state);
      if (o.cycles > 0 && (st == 0 || st == 5)) begin
        bus.mem_ack = 1'b0;
        o.end_state = st;
        done = 1'b1;
      end else begin
        case (st)
          0: bus.mem_ack = 1'b1;
          3: begin
            bus.mem_ack = (wait_n == v.dly);
            if (wait_n != v.dly) wait_n++;
          end
          // Stray acks with no request outstanding must be ignored.
          default: bus.mem_ack = 1'b1;
        endcase
        #1;
        if (bus.ir_load) n_ir++;
        if (bus.pc_load) begin
          o.n_pc++;
          o.pc_sel = int'(bus.pc_sel);
        end
        if (bus.we_rf) o.n_we++;
        case (st)
          1: o.mux_tgt = int'(bus.mux_tgt);
          2: begin
            o.alu_op  = int'(bus.alu_op);
            o.alu_src = int'(bus.alu_src);
          end
          3: begin
            if (bus.mem_req && bus.mem_addr_sel) o.n_mreq++;
            if (bus.mem_we) o.mem_we = 1;
          end
          4: o.mux_rf = int'(bus.mux_rf);
          default: ;
        endcase
        o.cycles++;
      end
    end
    check($sformatf("v%0d_done", idx), int'(done), 1);
    check($sformatf("v%0d_ir_load", idx), n_ir, 1);
    e = exp_q.pop_front();
    check($sformatf("v%0d_cycles", idx), o.cycles, e.cycles);
    check($sformatf("v%0d_we_rf", idx), o.n_we, e.n_we);
    check($sformatf("v%0d_pc_load", idx), o.n_pc, e.n_pc);
    check($sformatf("v%0d_pc_sel", idx), o.pc_sel, e.pc_sel);
    check($sformatf("v%0d_mux_rf", idx), o.mux_rf, e.mux_rf);
    check($sformatf("v%0d_alu_op", idx), o.alu_op, e.alu_op);
    check($sformatf("v%0d_alu_src", idx), o.alu_src, e.alu_src);
    check($sformatf("v%0d_mux_tgt", idx), o.mux_tgt, e.mux_tgt);
    check($sformatf("v%0d_mem_req", idx), o.n_mreq, e.n_mreq);
    check($sformatf("v%0d_mem_we", idx), o.mem_we, e.mem_we);
    check($sformatf("v%0d_end_state", idx), o.end_state, e.end_state);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit reached;
    int mcount;
    n_checks = 0;
    n_errors = 0;
    //          instr     eq  dly cyc we pc psel mrf aop src tgt mreq mwe end
    tbl[0]  = '{16'h2405, 1'b0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0}; // ADDI r1,r0,5
    tbl[1]  = '{16'h0082, 1'b0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // ADD r0
    tbl[2]  = '{16'h4C02, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0}; // NAND r3
    tbl[3]  = '{16'h6801, 1'b0, 0, 4, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0}; // LUI r2
    tbl[4]  = '{16'hC503, 1'b1, 0, 3, 0, 1, 1, 0, 3, 0, 1, 0, 0, 0}; // BEQ taken
    tbl[5]  = '{16'hC503, 1'b0, 0, 3, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0}; // BEQ not taken
    tbl[6]  = '{16'hA501, 1'b0, 3, 8, 1, 1, 0, 1, 0, 1, 0, 4, 0, 0}; // LW, ack at watchdog limit
    tbl[7]  = '{16'h8501, 1'b0, 0, 4, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0}; // SW
    tbl[8]  = '{16'h8501, 1'b0, 2, 6, 0, 1, 0, 0, 0, 1, 1, 3, 1, 0}; // SW, delayed ack
    tbl[9]  = '{16'hFC80, 1'b0, 0, 4, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0}; // JALR r7,r1
    tbl[10] = '{16'hE080, 1'b0, 0, 4, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0}; // JALR r0,r1
    tbl[11] = '{16'hE001, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5}; // JALR imm!=0 -> HALT

    rst         = 1'b1;
    bus.instr   = 16'h0000;
    bus.mem_ack = 1'b1;
    bus.alu_eq  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", int'(bus.state), 0);
    check("reset_mem_req", int'(bus.mem_req), 0);
    check("reset_ir_load", int'(bus.ir_load), 0);
    check("reset_halted", int'(bus.halted), 0);
    check("reset_fault", int'(bus.fault), 0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // HALT is terminal: stray acks change nothing.
    check("halt_halted", int'(bus.halted), 1);
    check("halt_fault", int'(bus.fault), 0);
    bus.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("halt_state_stays", int'(bus.state), 5);
      check("halt_mem_req", int'(bus.mem_req), 0);
      check("halt_pc_load", int'(bus.pc_load), 0);
    end

    // Reset in the middle of a stalled LW memory access.
    rst         = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    bus.instr = 16'hA501;
    reached   = 1'b0;
    mcount    = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      bus.mem_ack = (bus.state == 3'd0);
      if (bus.state == 3'd3) begin
        mcount++;
        if (mcount == 2) reached = 1'b1;
      end
    end
    check("midmem_reached", int'(reached), 1);
    #1;
    check("midmem_req_before", int'(bus.mem_req), 1);
    rst = 1'b1;
    #1;
    check("midmem_req_in_reset", int'(bus.mem_req), 0);
    check("midmem_state_in_reset", int'(bus.state), 0);
    check("midmem_addr_sel_in_reset", int'(bus.mem_addr_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0], 100);

    // Fetch watchdog: no ack ever arrives.
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("wd_state_waiting", int'(bus.state), 0);
      check("wd_fault_waiting", int'(bus.fault), 0);
      check("wd_mem_req_waiting", int'(bus.mem_req), 1);
    end
    @(negedge clk);
    #1;
    check("wd_state_expired", int'(bus.state), 5);
    check("wd_fault_expired", int'(bus.fault), 1);
    check("wd_halted_expired", int'(bus.halted), 0);
    bus.mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("wd_state_stays", int'(bus.state), 5);
      check("wd_fault_sticky", int'(bus.fault), 1);
    end
    rst = 1'b1;
    #1;
    check("wd_fault_cleared", int'(bus.fault), 0);
    check("wd_state_cleared", int'(bus.state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
